// File: rtl/eggs_game_ctrl_if.sv
// eggs_game_ctrl_if: key inputs and egg-count outputs of the game-control stage
interface eggs_game_ctrl_if;
    logic       btn_take;
    logic       btn_add;
    logic [2:0] num;
    logic       empty;
    logic       err;
    modport master (output btn_take, btn_add, input num, empty, err);
    modport slave (input btn_take, btn_add, output num, empty, err);
endinterface

// File: rtl/eggs_game_ctrl.sv
// eggs_game_ctrl: debounced two-key egg counter with empty/auto-refill sequence
module eggs_game_ctrl #(
    parameter int MAX_EGGS      = 4,
    parameter int DEB_CYCLES    = 20,
    parameter int REFILL_CYCLES = 3000
) (
    input logic            clk,
    input logic            rst,
    eggs_game_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(REFILL_CYCLES);
    localparam logic [2:0] MAX = 3'(MAX_EGGS);
    typedef enum logic {NORMAL, EMPTY} state_t;
    state_t        state_q, state_d;
    logic [1:0]    raw, s1_q, s2_q, db_q, db_prev_q, press;
    logic [DW-1:0] cnt_q [2];
    logic [2:0]    num_q, num_d;
    logic          err_q, err_d, empty_q;
    logic [RW-1:0] rcnt_q, rcnt_d;
    // bit 0 is the take key, bit 1 the add key
    assign raw   = {bus.btn_add, bus.btn_take};
    assign press = db_q & ~db_prev_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == db_q[i]) cnt_q[i] <= '0;
                else if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    db_q[i]  <= s2_q[i];
                    cnt_q[i] <= '0;
                end else cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        err_d   = 1'b0;
        rcnt_d  = rcnt_q;
        if (state_q == NORMAL) begin
            if (press[0] && !press[1]) begin
                if (num_q == 3'd0) err_d = 1'b1;
                else begin
                    num_d = num_q - 3'd1;
                    if (num_q == 3'd1) begin
                        state_d = EMPTY;
                        rcnt_d  = '0;
                    end
                end
            end else if (press[1] && !press[0]) begin
                if (num_q == MAX) err_d = 1'b1;
                else num_d = num_q + 3'd1;
            end
        end else begin
            rcnt_d = rcnt_q + 1'b1;
            // add wins over both a simultaneous take and the refill timeout
            if (press[1]) begin
                num_d   = 3'd1;
                state_d = NORMAL;
            end else if (rcnt_q == RW'(REFILL_CYCLES - 1)) begin
                num_d   = MAX;
                state_d = NORMAL;
            end else if (press[0]) err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            num_q   <= MAX;
            err_q   <= 1'b0;
            empty_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            err_q   <= err_d;
            empty_q <= (state_d == EMPTY);
            rcnt_q  <= rcnt_d;
        end
    end
    assign bus.num   = num_q;
    assign bus.empty = empty_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_eggs_game_ctrl.sv
// tb_eggs_game_ctrl: directed key sequences checked every cycle against a window-based model
module tb_eggs_game_ctrl;
    localparam int MAXE = 4;
    localparam int DEB  = 20;
    localparam int REF  = 3000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    eggs_game_ctrl_if bus ();
    eggs_game_ctrl #(.MAX_EGGS(MAXE), .DEB_CYCLES(DEB), .REFILL_CYCLES(REF)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    int cyc = 0;
    int m_num = MAXE;
    int enter = 0;
    bit m_empty = 1'b0;
    bit m_err = 1'b0;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    bit m_dbp [2];
    bit [DEB-1:0] win [2];
    bit lit_on = 1'b0;
    string lit_name = "";
    int lit_num = 0;
    bit lit_empty = 1'b0;
    bit lit_err = 1'b0;

    // a key level is accepted once the last DEB synchronised samples all disagree with it
    always @(posedge clk) begin
        logic [1:0] raw;
        bit tp, ap;
        raw = {bus.btn_add, bus.btn_take};
        cyc++;
        if (rst) begin
            m_num = MAXE;
            m_empty = 1'b0;
            m_err = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_db[k] = 1'b0; m_dbp[k] = 1'b0; win[k] = '0;
            end
        end else begin
            tp = m_db[0] && !m_dbp[0];
            ap = m_db[1] && !m_dbp[1];
            m_err = 1'b0;
            if (!m_empty) begin
                if (tp && !ap) begin
                    if (m_num == 0) m_err = 1'b1;
                    else begin
                        m_num--;
                        if (m_num == 0) begin
                            m_empty = 1'b1;
                            enter = cyc;
                        end
                    end
                end else if (ap && !tp) begin
                    if (m_num == MAXE) m_err = 1'b1;
                    else m_num++;
                end
            end else if (ap) begin
                m_num = 1;
                m_empty = 1'b0;
            end else if (cyc - enter == REF) begin
                m_num = MAXE;
                m_empty = 1'b0;
            end else if (tp) m_err = 1'b1;
            for (int k = 0; k < 2; k++) begin
                win[k] = {win[k][DEB-2:0], m_s2[k]};
                m_dbp[k] = m_db[k];
                if (m_db[k] ? (win[k] == '0) : (&win[k])) m_db[k] = !m_db[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = raw[k];
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            vecs++;
            if ({bus.num, bus.empty, bus.err} !== {3'(m_num), m_empty, m_err}) begin
                miss++;
                $display("FAIL model cyc=%0d: got num=%0d empty=%0b err=%0b, want num=%0d empty=%0b err=%0b",
                         cyc, bus.num, bus.empty, bus.err, m_num, m_empty, m_err);
            end
            if (lit_on) begin
                vecs++;
                if ({bus.num, bus.empty, bus.err} !== {3'(lit_num), lit_empty, lit_err}) begin
                    miss++;
                    $display("FAIL %s cyc=%0d: got num=%0d empty=%0b err=%0b, want num=%0d empty=%0b err=%0b",
                             lit_name, cyc, bus.num, bus.empty, bus.err, lit_num, lit_empty, lit_err);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            lit_on = 1'b0;
            #3;
        end
    endtask

    task automatic lit(input string nm, input int n, input bit e, input bit r);
        lit_name = nm;
        lit_num = n;
        lit_empty = e;
        lit_err = r;
        lit_on = 1'b1;
    endtask

    task automatic press(input bit take, input bit add);
        bus.btn_take = take;
        bus.btn_add = add;
        tick(30);
        bus.btn_take = 1'b0;
        bus.btn_add = 1'b0;
        tick(30);
    endtask

    initial begin
        int glitch [3] = '{5, 19, 20};
        bus.btn_take = 1'b0;
        bus.btn_add = 1'b0;
        tick(3);
        lit("reset", 4, 1'b0, 1'b0);
        rst = 1'b0;
        for (int n = 3; n >= 0; n--) begin
            bus.btn_take = 1'b1;
            tick(22);
            lit("take_pre", n + 1, 1'b0, 1'b0);
            tick(1);
            lit("take_upd", n, n == 0, 1'b0);
            tick(7);
            bus.btn_take = 1'b0;
            if (n > 0) tick(30);
        end
        tick(2992);
        lit("refill_pre", 0, 1'b1, 1'b0);
        tick(1);
        lit("refill", 4, 1'b0, 1'b0);
        tick(30);
        foreach (glitch[g]) begin
            bus.btn_take = 1'b1;
            tick(glitch[g]);
            bus.btn_take = 1'b0;
            tick(40);
            lit("glitch", glitch[g] == 20 ? 3 : 4, 1'b0, 1'b0);
        end
        bus.btn_add = 1'b1;
        tick(23);
        lit("add", 4, 1'b0, 1'b0);
        tick(7);
        bus.btn_add = 1'b0;
        tick(30);
        bus.btn_add = 1'b1;
        tick(22);
        lit("rej_pre", 4, 1'b0, 1'b0);
        tick(1);
        lit("rej_err", 4, 1'b0, 1'b1);
        tick(1);
        lit("rej_one", 4, 1'b0, 1'b0);
        tick(6);
        bus.btn_add = 1'b0;
        tick(30);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        lit("at2", 2, 1'b0, 1'b0);
        press(1'b1, 1'b1);
        lit("both_2", 2, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        lit("empty", 0, 1'b1, 1'b0);
        bus.btn_take = 1'b1;
        tick(23);
        lit("empty_take", 0, 1'b1, 1'b1);
        tick(7);
        bus.btn_take = 1'b0;
        tick(30);
        bus.btn_take = 1'b1;
        bus.btn_add = 1'b1;
        tick(23);
        lit("both_0", 1, 1'b0, 1'b0);
        tick(7);
        bus.btn_take = 1'b0;
        bus.btn_add = 1'b0;
        tick(30);
        bus.btn_take = 1'b1;
        tick(23);
        lit("empty2", 0, 1'b1, 1'b0);
        tick(7);
        bus.btn_take = 1'b0;
        tick(70);
        bus.btn_add = 1'b1;
        tick(23);
        lit("add_100", 1, 1'b0, 1'b0);
        tick(7);
        bus.btn_add = 1'b0;
        tick(3000);
        lit("no_refill", 1, 1'b0, 1'b0);
        bus.btn_take = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(3);
        lit("rst_mid", 4, 1'b0, 1'b0);
        rst = 1'b0;
        tick(22);
        lit("rst_pre", 4, 1'b0, 1'b0);
        tick(1);
        lit("rst_take", 3, 1'b0, 1'b0);
        tick(50);
        lit("held", 3, 1'b0, 1'b0);
        tick(1);
        bus.btn_take = 1'b0;
        tick(30);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/eggs_game_ctrl.md
# eggs_game_ctrl

Game-control stage that turns two raw push-button inputs into the 3-bit egg count consumed by the dot-matrix display driver (its `num` input). It synchronises and debounces both keys and keeps the count between 0 and MAX_EGGS. When the count reaches zero it runs an empty/auto-refill sequence. It runs on the same 1 kHz scan clock as the display driver.

## Interface
- MAX_EGGS, 4, full egg count (1..7); value loaded at reset and on refill
- DEB_CYCLES, 20, consecutive stable cycles required to accept a key level change (≥2)
- REFILL_CYCLES, 3000, cycles spent in EMPTY before automatic refill (≥2)
- clk  in  1  1 kHz system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- btn_take  in  1  raw key, asynchronous, active-high; press removes one egg
- btn_add  in  1  raw key, asynchronous, active-high; press adds one egg
- num  out  3  registered egg count 0..MAX_EGGS; drives display `num`
- empty  out  1  registered; high while FSM is in EMPTY
- err  out  1  registered one-cycle pulse on a rejected press

## Operation
- Input path, per key: 2-flop synchroniser (s1, s2), then debouncer holding stable level `db`.
  - Debounce counter width: ceil(log2(DEB_CYCLES+1)).
  - The counter increments each cycle s2 ≠ db and clears whenever s2 = db.
  - On the cycle the counter would reach DEB_CYCLES, `db` takes s2 and the counter clears.
  - A press is a one-cycle pulse on `db` 0→1 (db & ~db_d). Releases generate nothing.
- FSM states: NORMAL, EMPTY. Reset enters NORMAL.
- NORMAL:
  - take pulse with num>0: num−1.
  - take pulse with num=0: no change; err pulse. This cannot normally occur; it is defensive only.
  - add pulse with num<MAX_EGGS: num+1.
  - add pulse with num=MAX_EGGS: no change; err pulse.
  - Take and add pulses in the same cycle: no change, no err.
  - A take that sets num to 0 moves the FSM to EMPTY on the same edge. The refill counter clears and `empty` goes high on that edge.
- EMPTY:
  - Refill counter (12 bits at default) increments every cycle.
  - Counter reaching REFILL_CYCLES−1: num←MAX_EGGS, go to NORMAL, empty←0.
  - add pulse: num←1, go to NORMAL, empty←0. This takes priority over refill on the same cycle.
  - take pulse: err pulse; no change.
  - Take and add pulses in the same cycle: treated as add.
- Arithmetic: 3-bit unsigned. num never wraps; saturation is enforced by the rules above, never by overflow.

## Timing
- Reset values:
  - num=MAX_EGGS, empty=0, err=0.
  - State NORMAL.
  - All synchroniser flops, db, db_d and counters cleared to 0.
- Press latency, with the raw key going high and stable before edge 1:
  - s2=1 after edge 2.
  - db=1 after edge DEB_CYCLES+2.
  - num/err update at edge DEB_CYCLES+3. This is 23 edges at default.
- A raw glitch shorter than DEB_CYCLES cycles (after synchronisation) produces no pulse.
- A held key produces exactly one press. A new press requires db to return to 0, i.e. the key is released and stable for DEB_CYCLES cycles.
- Refill latency: exactly REFILL_CYCLES edges from the edge that entered EMPTY to the edge that loads MAX_EGGS.
- err is high for exactly one cycle per rejected press.
- Reset mid-operation:
  - Any in-progress debounce or refill is discarded.
  - A key held through reset deassertion is treated as a fresh press and takes effect DEB_CYCLES+3 edges after the first non-reset edge.
- num changes at most once per cycle. The display stage re-registers it, so the downstream view is one extra cycle late.

## Test plan
- Reset with both keys low → num=4, empty=0, err=0. Four clean take presses, each held for 30 cycles → num 3,2,1,0. Each update lands 23 edges after its press. empty rises on the edge num becomes 0.
- btn_take glitches of 5 and 19 cycles → no num change. A 20-cycle stable pulse → exactly one decrement.
- At num=4, press add → num stays 4 and err is high for exactly one cycle. At num=0 (EMPTY), press take → err pulse, num stays 0.
- Enter EMPTY and press nothing → num=4 and empty=0 exactly 3000 edges after entry. Repeat with an add press landing 100 cycles into EMPTY → num=1, empty=0, and no later refill.
- Raise both keys on the same cycle and hold them at num=2 → num stays 2, err=0. Repeat at num=0 → num=1.
- Hold btn_take, assert rst for 3 cycles mid-debounce, then keep the key held → num=4 right after reset, then num=3 exactly 23 edges after rst deasserts, with no further change while the key stays held.
